// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-word holding buffer.
// Frames are start, DATA_W data bits LSB first, optional parity, stop bits.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CFIN = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0] DLAST = 4'(DATA_W - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [3:0]          bit_q;
  logic [DATA_W-1:0]   sh_q;
  logic [DATA_W-1:0]   buf_q;
  logic                full_q;
  logic                par_q;
  logic                tx_q;
  logic                busy_q;
  logic                done_q;

  logic accept_d;
  logic bit_end_d;
  logic stop_end_d;
  logic load_d;

  always_comb begin
    accept_d   = tx_valid & ~full_q;
    bit_end_d  = (cnt_q == CMAX);
    stop_end_d = (state_q == STOP) && bit_end_d && (bit_q == SLAST);
    load_d     = full_q && ((state_q == IDLE) || stop_end_d);
  end

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_d) begin
        buf_q  <= tx_data;
        full_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: cnt_q <= '0;
        START: begin
          if (bit_end_d) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end_d) begin
            cnt_q <= '0;
            if (bit_q == DLAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q <= PAR;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PAR: begin
          if (bit_end_d) begin
            state_q <= STOP;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          // pulse lands in the final cycle of the last stop bit
          if (bit_q == SLAST && cnt_q == CFIN)
            done_q <= 1'b1;
          if (bit_end_d) begin
            cnt_q <= '0;
            if (bit_q == SLAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (load_d) begin
        state_q <= START;
        cnt_q   <= '0;
        sh_q    <= buf_q;
        par_q   <= (^buf_q) ^ ODD;
        full_q  <= 1'b0;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end
    end
  end

  assign tx_ready   = ~full_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations driven with random and
// directed words, compared against a per-cycle frame model.
module tb_uart_tx_param;

  localparam int DWA[5] = '{8, 8, 8, 8, 5};
  localparam int PA[5]  = '{0, 1, 2, 0, 0};
  localparam int SA[5]  = '{1, 1, 1, 2, 1};
  localparam int CA[5]  = '{4, 4, 4, 4, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] valids;
  logic [8:0] tx_data [5];
  logic [4:0] txs, busys, dones, readys;

  int checks = 0;
  int errors = 0;

  logic [255:0] otx, obusy, odone, ordy;
  logic [255:0] etx, ebusy, edone;
  int           acc;
  logic [8:0]   wq[$];
  logic [8:0]   sq[$];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1),
                  .CLKS_PER_BIT(4)) u0 (
    .clk_sis(clk), .rst(rst), .tx_valid(valids[0]),
    .tx_data(tx_data[0][7:0]), .tx_ready(readys[0]),
    .tx(txs[0]), .busy(busys[0]), .frame_done(dones[0]));

  uart_tx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1),
                  .CLKS_PER_BIT(4)) u1 (
    .clk_sis(clk), .rst(rst), .tx_valid(valids[1]),
    .tx_data(tx_data[1][7:0]), .tx_ready(readys[1]),
    .tx(txs[1]), .busy(busys[1]), .frame_done(dones[1]));

  uart_tx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1),
                  .CLKS_PER_BIT(4)) u2 (
    .clk_sis(clk), .rst(rst), .tx_valid(valids[2]),
    .tx_data(tx_data[2][7:0]), .tx_ready(readys[2]),
    .tx(txs[2]), .busy(busys[2]), .frame_done(dones[2]));

  uart_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(2),
                  .CLKS_PER_BIT(4)) u3 (
    .clk_sis(clk), .rst(rst), .tx_valid(valids[3]),
    .tx_data(tx_data[3][7:0]), .tx_ready(readys[3]),
    .tx(txs[3]), .busy(busys[3]), .frame_done(dones[3]));

  uart_tx_param #(.DATA_W(5), .PARITY(0), .STOP_BITS(1),
                  .CLKS_PER_BIT(2)) u4 (
    .clk_sis(clk), .rst(rst), .tx_valid(valids[4]),
    .tx_data(tx_data[4][4:0]), .tx_ready(readys[4]),
    .tx(txs[4]), .busy(busys[4]), .frame_done(dones[4]));

  function automatic int flen(input int i);
    int p;
    p = (PA[i] != 0) ? 1 : 0;
    return (1 + DWA[i] + p + SA[i]) * CA[i];
  endfunction

  function automatic logic [8:0] rnd(input int i);
    return 9'($urandom_range(0, (1 << DWA[i]) - 1));
  endfunction

  // Feed wq with valid held while words remain; record outputs per cycle.
  task automatic run(input int i, input int n);
    logic rp;
    otx = '0; obusy = '0; odone = '0; ordy = '0; acc = 0;
    rp = readys[i];
    if (wq.size() > 0) begin
      valids[i] = 1'b1;
      tx_data[i] = wq[0];
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      otx[k] = txs[i];
      obusy[k] = busys[i];
      odone[k] = dones[i];
      ordy[k] = readys[i];
      if (valids[i] && rp) begin
        void'(wq.pop_front());
        acc++;
      end
      if (wq.size() > 0) begin
        valids[i] = 1'b1;
        tx_data[i] = wq[0];
      end else begin
        valids[i] = 1'b0;
      end
      rp = readys[i];
    end
  endtask

  // Frames run back to back from sample 2 (accept edge, then load edge).
  task automatic build_exp(input int i, input int n);
    int c, dw, l, f, pos, b;
    logic [8:0] w;
    logic p;
    c = CA[i]; dw = DWA[i]; l = flen(i);
    etx = '0; ebusy = '0; edone = '0;
    for (int k = 1; k <= n; k++) begin
      if (k >= 2 && (k - 2) / l < sq.size()) begin
        f = (k - 2) / l;
        pos = (k - 2) % l;
        b = pos / c;
        w = sq[f];
        ebusy[k] = 1'b1;
        edone[k] = (pos == l - 1);
        p = (PA[i] == 2);
        for (int j = 0; j < dw; j++) p = p ^ w[j];
        if (b == 0) etx[k] = 1'b0;
        else if (b <= dw) etx[k] = w[b-1];
        else if (PA[i] != 0 && b == dw + 1) etx[k] = p;
        else etx[k] = 1'b1;
      end else begin
        etx[k] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({txs[i], busys[i], dones[i], readys[i]} !== 4'b1001) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %b exp 1001", i,
                 {txs[i], busys[i], dones[i], readys[i]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({txs[i], busys[i], dones[i], readys[i]} !== 4'b1001) begin
        errors++;
        $display("FAIL reset_idle[%0d] got %b exp 1001", i,
                 {txs[i], busys[i], dones[i], readys[i]});
      end
    end
  endtask

  task automatic test_stream(input string nm, input int i,
                             input int nw, input logic [8:0] w0,
                             input logic [8:0] w1);
    int n;
    wq.delete();
    wq.push_back(w0);
    if (nw > 1) wq.push_back(w1);
    for (int j = 2; j < nw; j++) wq.push_back(rnd(i));
    sq = wq;
    n = 2 + nw * flen(i) + 3;
    run(i, n);
    build_exp(i, n);
    checks++;
    if (otx !== etx) begin
      errors++;
      $display("FAIL %s_tx got %h exp %h", nm, otx, etx);
    end
    checks++;
    if (obusy !== ebusy) begin
      errors++;
      $display("FAIL %s_busy got %h exp %h", nm, obusy, ebusy);
    end
    checks++;
    if (odone !== edone) begin
      errors++;
      $display("FAIL %s_done got %h exp %h", nm, odone, edone);
    end
    checks++;
    if (acc !== nw) begin
      errors++;
      $display("FAIL %s_accepts got %0d exp %0d", nm, acc, nw);
    end
  endtask

  task automatic test_buffer_full();
    int n;
    wq.delete();
    for (int j = 0; j < 3; j++) wq.push_back(rnd(0));
    sq = wq;
    n = 2 + 3 * flen(0) + 3;
    run(0, n);
    build_exp(0, n);
    checks++;
    if (ordy[1] !== 1'b0 || ordy[5] !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b%b exp 00", ordy[1], ordy[5]);
    end
    checks++;
    if (otx !== etx) begin
      errors++;
      $display("FAIL full_tx got %h exp %h", otx, etx);
    end
    checks++;
    if (odone !== edone) begin
      errors++;
      $display("FAIL full_done got %h exp %h", odone, edone);
    end
    checks++;
    if (acc !== 3) begin
      errors++;
      $display("FAIL full_accepts got %0d exp 3", acc);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    valids[0] = 1'b1;
    tx_data[0] = 9'h03C;
    @(negedge clk);
    @(negedge clk);
    tx_data[0] = 9'h0C3;
    @(negedge clk);
    valids[0] = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (busys[0] !== 1'b1 || readys[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got busy=%b rdy=%b exp 1 0",
               busys[0], readys[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({txs[0], busys[0], dones[0], readys[0]} !== 4'b1001) begin
      errors++;
      $display("FAIL mid_async got %b exp 1001",
               {txs[0], busys[0], dones[0], readys[0]});
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (dones[0] !== 1'b0 || txs[0] !== 1'b1) bad++;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (dones[0] !== 1'b0 || txs[0] !== 1'b1 || busys[0] !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL mid_quiet got %0d bad cycles exp 0", bad);
    end
    test_stream("after_rst", 0, 1, 9'h0A5, 9'h000);
  endtask

  initial begin
    rst = 1'b1;
    valids = '0;
    for (int i = 0; i < 5; i++) tx_data[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_stream("basic", 0, 1, 9'h05B, 9'h000);
    test_stream("basic_rnd", 0, 3, rnd(0), rnd(0));
    test_stream("even", 1, 1, 9'h05B, 9'h000);
    test_stream("even_rnd", 1, 3, rnd(1), rnd(1));
    test_stream("odd", 2, 1, 9'h05B, 9'h000);
    test_stream("odd_rnd", 2, 3, rnd(2), rnd(2));
    test_stream("b2b", 3, 2, 9'h0FF, 9'h000);
    test_stream("b2b_rnd", 3, 3, rnd(3), rnd(3));
    test_buffer_full();
    test_reset_mid();
    test_stream("narrow", 4, 1, 9'h013, 9'h000);
    test_stream("narrow_rnd", 4, 4, rnd(4), rnd(4));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
